// File: rtl/arb42_pkg.sv
// Shared types and the round-robin pick function for the four-requester arbiter.
package arb42_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // First asserted request found walking upward from ptr, wrapping 3 -> 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/encoder42.sv
// 4-to-2 binary encoder for a one-hot (or all-zero) input; bit 0 needs no input
// because it encodes to 00, the same as no input at all.
module encoder42 (
  input  logic d1,
  input  logic d2,
  input  logic d3,
  output logic o0,
  output logic o1
);

  assign o0 = d1 | d3;
  assign o1 = d2 | d3;

endmodule

// File: rtl/arbiter42_rr.sv
// Four-requester round-robin arbiter with registered one-hot grant and encoded index.
// Define ARB42_TIMEOUT_EN to compile in the HOLD_MAX grant timeout and timeout pulse.
module arbiter42_rr
  import arb42_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic req4,
  output logic gnt1,
  output logic gnt2,
  output logic gnt3,
  output logic gnt4,
  output logic o0,
  output logic o1,
  output logic valid,
  output logic timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_illegal
    $error("arbiter42_rr: HOLD_MAX must be in 1..255");
  end

  arb_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic [N_REQ-1:0]  gnt_reg, gnt_next;
  logic [N_REQ-1:0]  req_vec;
  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  owner_idx;
  logic              owner_req;
  logic              hold_expired;
  logic              release_now;

  assign req_vec  = {req4, req3, req2, req1};
  assign pick_idx = rr_pick(req_vec, ptr_reg);

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_pick_decode
    assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
  end

  // The owner index comes from the encoded registered grant, so it is valid only in BUSY.
  encoder42 u_encoder42 (
    .d1 (gnt_reg[1]),
    .d2 (gnt_reg[2]),
    .d3 (gnt_reg[3]),
    .o0 (o0),
    .o1 (o1)
  );

  assign owner_idx   = {o1, o0};
  assign owner_req   = req_vec[owner_idx];
  assign release_now = !owner_req || hold_expired;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req_vec) state_next = BUSY;
      BUSY:    if (release_now) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt_next = gnt_reg;
    ptr_next = ptr_reg;
    case (state_reg)
      IDLE: begin
        gnt_next = (|req_vec) ? pick_onehot : '0;
      end
      BUSY: begin
        if (release_now) begin
          gnt_next = '0;
          ptr_next = owner_idx + IDX_W'(1);
        end
      end
      default: gnt_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_reg <= '0;
      ptr_reg <= '0;
    end else begin
      gnt_reg <= gnt_next;
      ptr_reg <= ptr_next;
    end
  end

`ifdef ARB42_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] cnt_reg, cnt_next;
  logic       timeout_reg;

  assign hold_expired = (state_reg == BUSY) && (cnt_reg == HOLD_LAST);
  assign cnt_next     = (state_reg == BUSY) ? cnt_reg + 8'd1 : 8'd0;

  // An owner drop on the expiry edge is an ordinary release, hence the owner_req term.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg     <= 8'd0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= hold_expired && owner_req;
    end
  end

  assign timeout = timeout_reg;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  assign gnt1  = gnt_reg[0];
  assign gnt2  = gnt_reg[1];
  assign gnt3  = gnt_reg[2];
  assign gnt4  = gnt_reg[3];
  assign valid = |gnt_reg;

endmodule

// File: tb/tb_arbiter42_rr.sv
// Directed bench for arbiter42_rr; the timeout scenario follows ARB42_TIMEOUT_EN.
module tb_arbiter42_rr;

  logic clk = 1'b0;
  logic rst_n;
  logic req1, req2, req3, req4;
  logic gnt1, gnt2, gnt3, gnt4;
  logic o0, o1, valid, timeout;

  int checks   = 0;
  int failures = 0;

  // Packed view: {gnt4, gnt3, gnt2, gnt1, o1, o0, valid, timeout}
  localparam logic [7:0] E_IDLE = 8'b0000_00_0_0;
  localparam logic [7:0] E_G1   = 8'b0001_00_1_0;
  localparam logic [7:0] E_G2   = 8'b0010_01_1_0;
  localparam logic [7:0] E_G3   = 8'b0100_10_1_0;
  localparam logic [7:0] E_G4   = 8'b1000_11_1_0;
  localparam logic [7:0] E_TO   = 8'b0000_00_0_1;

  logic [7:0] obs;
  assign obs = {gnt4, gnt3, gnt2, gnt1, o1, o0, valid, timeout};

  arbiter42_rr #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req1    (req1),
    .req2    (req2),
    .req3    (req3),
    .req4    (req4),
    .gnt1    (gnt1),
    .gnt2    (gnt2),
    .gnt3    (gnt3),
    .gnt4    (gnt4),
    .o0      (o0),
    .o1      (o1),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    {req4, req3, req2, req1} = r;
  endtask

  function automatic logic [7:0] gnt_exp(input int k);
    case (k)
      0:       return E_G1;
      1:       return E_G2;
      2:       return E_G3;
      default: return E_G4;
    endcase
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    set_req(4'b1111);
    tick();
    tick();
    checks++;
    if (obs !== E_IDLE) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b", obs, E_IDLE);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== E_G1) begin
      failures++;
      $display("FAIL reset_first_grant: got %b expected %b", obs, E_G1);
    end
    $display("test_reset: outputs=%b", obs);
  endtask

  task automatic test_rotation;
    logic [3:0] r;
    r = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++;
        if (obs !== gnt_exp(k)) begin
          failures++;
          $display("FAIL rr_hold owner=%0d: got %b expected %b", k, obs, gnt_exp(k));
        end
      end
      r[k] = 1'b0;
      set_req(r);
      tick();
      checks++;
      if (obs !== E_IDLE) begin
        failures++;
        $display("FAIL rr_idle_gap owner=%0d: got %b expected %b", k, obs, E_IDLE);
      end
      r[k] = 1'b1;
      set_req(r);
      tick();
      checks++;
      if (obs !== gnt_exp((k + 1) % 4)) begin
        failures++;
        $display("FAIL rr_next after=%0d: got %b expected %b", k, obs, gnt_exp((k + 1) % 4));
      end
      $display("test_rotation: owner %0d released, next outputs=%b", k, obs);
    end
    set_req(4'b0000);
    tick();
    checks++;
    if (obs !== E_IDLE) begin
      failures++;
      $display("FAIL rr_final_release: got %b expected %b", obs, E_IDLE);
    end
  endtask

  task automatic test_no_preempt;
    set_req(4'b0100);
    tick();
    checks++;
    if (obs !== E_G3) begin
      failures++;
      $display("FAIL np_grant3: got %b expected %b", obs, E_G3);
    end
    set_req(4'b0101);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs !== E_G3) begin
        failures++;
        $display("FAIL np_hold3: got %b expected %b", obs, E_G3);
      end
    end
    set_req(4'b0001);
    tick();
    checks++;
    if (obs !== E_IDLE) begin
      failures++;
      $display("FAIL np_idle_gap: got %b expected %b", obs, E_IDLE);
    end
    tick();
    checks++;
    if (obs !== E_G1) begin
      failures++;
      $display("FAIL np_grant1: got %b expected %b", obs, E_G1);
    end
    set_req(4'b0000);
    tick();
    checks++;
    if (obs !== E_IDLE) begin
      failures++;
      $display("FAIL np_release: got %b expected %b", obs, E_IDLE);
    end
    $display("test_no_preempt: done, outputs=%b", obs);
  endtask

`ifdef ARB42_TIMEOUT_EN
  task automatic test_timeout;
    set_req(4'b0010);
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (obs !== E_G2) begin
        failures++;
        $display("FAIL to_hold cycle=%0d: got %b expected %b", c, obs, E_G2);
      end
    end
    tick();
    checks++;
    if (obs !== E_TO) begin
      failures++;
      $display("FAIL to_pulse: got %b expected %b", obs, E_TO);
    end
    tick();
    checks++;
    if (obs !== E_G2) begin
      failures++;
      $display("FAIL to_regrant: got %b expected %b", obs, E_G2);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs !== E_G2) begin
        failures++;
        $display("FAIL to_rehold cycle=%0d: got %b expected %b", c, obs, E_G2);
      end
    end
    // Drop on the same edge the hold expires: plain release, no pulse.
    set_req(4'b0000);
    tick();
    checks++;
    if (obs !== E_IDLE) begin
      failures++;
      $display("FAIL to_drop_on_expiry: got %b expected %b", obs, E_IDLE);
    end
    tick();
    checks++;
    if (obs !== E_IDLE) begin
      failures++;
      $display("FAIL to_quiet: got %b expected %b", obs, E_IDLE);
    end
    $display("test_timeout: done, outputs=%b", obs);
  endtask
`else
  task automatic test_timeout;
    set_req(4'b0010);
    tick();
    checks++;
    if (obs !== E_G2) begin
      failures++;
      $display("FAIL nto_grant2: got %b expected %b", obs, E_G2);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (obs !== E_G2) begin
        failures++;
        $display("FAIL nto_long_hold cycle=%0d: got %b expected %b", c, obs, E_G2);
      end
    end
    set_req(4'b0000);
    tick();
    checks++;
    if (obs !== E_IDLE) begin
      failures++;
      $display("FAIL nto_release: got %b expected %b", obs, E_IDLE);
    end
    $display("test_timeout: unbounded hold done, outputs=%b", obs);
  endtask
`endif

  task automatic test_reset_mid_grant;
    set_req(4'b1000);
    tick();
    checks++;
    if (obs !== E_G4) begin
      failures++;
      $display("FAIL rmg_grant4: got %b expected %b", obs, E_G4);
    end
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (obs !== E_IDLE) begin
      failures++;
      $display("FAIL rmg_reset_drop: got %b expected %b", obs, E_IDLE);
    end
    rst_n = 1'b1;
    set_req(4'b1001);
    tick();
    checks++;
    if (obs !== E_G1) begin
      failures++;
      $display("FAIL rmg_ptr_zero: got %b expected %b", obs, E_G1);
    end
    set_req(4'b1000);
    tick();
    checks++;
    if (obs !== E_IDLE) begin
      failures++;
      $display("FAIL rmg_release1: got %b expected %b", obs, E_IDLE);
    end
    tick();
    checks++;
    if (obs !== E_G4) begin
      failures++;
      $display("FAIL rmg_then4: got %b expected %b", obs, E_G4);
    end
    set_req(4'b0000);
    tick();
    $display("test_reset_mid_grant: done, outputs=%b", obs);
  endtask

  task automatic test_back_to_back;
    set_req(4'b1110);
    tick();
    checks++;
    if (obs !== E_G2) begin
      failures++;
      $display("FAIL b2b_grant2: got %b expected %b", obs, E_G2);
    end
    set_req(4'b1100);
    tick();
    tick();
    checks++;
    if (obs !== E_G3) begin
      failures++;
      $display("FAIL b2b_grant3: got %b expected %b", obs, E_G3);
    end
    set_req(4'b1000);
    tick();
    checks++;
    if (obs !== E_IDLE) begin
      failures++;
      $display("FAIL b2b_gap: got %b expected %b", obs, E_IDLE);
    end
    tick();
    checks++;
    if (obs !== E_G4) begin
      failures++;
      $display("FAIL b2b_grant4: got %b expected %b", obs, E_G4);
    end
    set_req(4'b0000);
    tick();
    checks++;
    if (obs !== E_IDLE) begin
      failures++;
      $display("FAIL b2b_release: got %b expected %b", obs, E_IDLE);
    end
    $display("test_back_to_back: done, outputs=%b", obs);
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(4'b0000);
    test_reset();
    test_rotation();
    test_no_preempt();
    test_timeout();
    test_reset_mid_grant();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
